// File: rtl/output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : output_port_arbiter
// Brief    : Round-robin arbiter that shares one leaf-to-network packet lane
//            among NUM_PORTS output-port queues. The granted port returns its
//            packet one cycle after the read select. The packet is captured
//            into a 2-entry skid buffer and offered downstream with a
//            valid/ready handshake, so backpressure never loses a packet.
// Revision : 1.0 - initial release
// ============================================================================
module output_port_arbiter #(
    parameter int NUM_PORTS     = 4,
    parameter int PORT_IDX_BITS = 2,
    parameter int PACKET_BITS   = 97,
    parameter int CNT_BITS      = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             port_empty,
    input  logic [NUM_PORTS-1:0]             port_credit,
    input  logic [NUM_PORTS*PACKET_BITS-1:0] port_pkt,
    output logic [NUM_PORTS-1:0]             rd_en_sel,
    output logic [PACKET_BITS-1:0]           out_pkt,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [PORT_IDX_BITS-1:0]         grant_idx,
    input  logic                             is_done_mode,
    output logic [CNT_BITS-1:0]              stall_cnt,
    output logic [CNT_BITS-1:0]              drop_cnt
);

    localparam logic [CNT_BITS-1:0]      c_cnt_max     = '1;
    localparam logic [PORT_IDX_BITS-1:0] c_last_port   = PORT_IDX_BITS'(NUM_PORTS - 1);
    localparam logic [1:0]               c_occ_empty   = 2'd0;
    localparam logic [1:0]               c_occ_one     = 2'd1;
    localparam logic [1:0]               c_occ_full    = 2'd2;

    // Skid buffer: r_buf0 is always the head, r_buf1 the second entry.
    logic [1:0]               r_occ;
    logic [PACKET_BITS-1:0]   r_buf0;
    logic [PACKET_BITS-1:0]   r_buf1;

    // Arbitration state.
    logic                     r_inflight;
    logic [PORT_IDX_BITS-1:0] r_rr_ptr;
    logic [PORT_IDX_BITS-1:0] r_issued_idx;
    logic [PORT_IDX_BITS-1:0] r_grant_idx;

    // Performance counters.
    logic [CNT_BITS-1:0]      r_stall_cnt;
    logic [CNT_BITS-1:0]      r_drop_cnt;

    logic [NUM_PORTS-1:0]     w_eligible;
    logic                     w_pop;
    logic [2:0]               w_budget;
    logic                     w_allowed;
    logic                     w_any;
    logic [PORT_IDX_BITS-1:0] w_sel_idx;
    logic                     w_issue;
    logic [PACKET_BITS-1:0]   w_cap_pkt;
    logic                     w_push;
    logic                     w_drop;
    logic                     w_stall;

    assign w_eligible = ~port_empty & port_credit;
    assign out_valid  = (r_occ != c_occ_empty);
    assign out_pkt    = r_buf0;
    assign w_pop      = out_valid & out_ready;

    // Entries already held plus the packet still on its way back from a port.
    // A new issue is safe only if that total, less this cycle's pop, stays
    // below the buffer depth, so the packet it fetches is guaranteed a slot.
    assign w_budget   = {1'b0, r_occ} + {2'b00, r_inflight};
    assign w_allowed  = w_pop ? (w_budget < 3'd3) : (w_budget < 3'd2);

    assign w_issue    = ~reset & w_allowed & w_any;

    // Packet returned by the port issued last cycle; its top bit is the
    // valid flag, cleared when the port declined the read.
    assign w_push     = r_inflight & w_cap_pkt[PACKET_BITS-1];
    assign w_drop     = r_inflight & ~w_cap_pkt[PACKET_BITS-1];
    assign w_stall    = out_valid & ~out_ready;

    assign grant_idx  = r_grant_idx;
    assign stall_cnt  = r_stall_cnt;
    assign drop_cnt   = r_drop_cnt;

    // Round-robin search: first eligible port after the last grant, wrapping.
    always_comb begin
        int cand;
        cand      = 0;
        w_any     = 1'b0;
        w_sel_idx = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = (int'(r_rr_ptr) + k) % NUM_PORTS;
            if (!w_any && w_eligible[PORT_IDX_BITS'(cand)]) begin
                w_any     = 1'b1;
                w_sel_idx = PORT_IDX_BITS'(cand);
            end
        end
    end

    // One-hot read select toward the ports; zero whenever nothing is issued.
    always_comb begin
        rd_en_sel = '0;
        if (w_issue) begin
            rd_en_sel[w_sel_idx] = 1'b1;
        end
    end

    // Select the returning packet from the port that was issued last cycle.
    always_comb begin
        w_cap_pkt = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_issued_idx == PORT_IDX_BITS'(i)) begin
                w_cap_pkt = port_pkt[i*PACKET_BITS +: PACKET_BITS];
            end
        end
    end

    // Arbitration state: remember the grant and track the in-flight read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr     <= c_last_port;
            r_grant_idx  <= '0;
            r_issued_idx <= '0;
            r_inflight   <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rr_ptr     <= w_sel_idx;
                r_grant_idx  <= w_sel_idx;
                r_issued_idx <= w_sel_idx;
            end
        end
    end

    // Two-entry FIFO skid buffer; the head stays put after the last pop so
    // out_pkt holds its final value while out_valid is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ  <= c_occ_empty;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == c_occ_empty) begin
                        r_buf0 <= w_cap_pkt;
                    end else begin
                        r_buf1 <= w_cap_pkt;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    if (r_occ == c_occ_full) begin
                        r_buf0 <= r_buf1;
                    end
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == c_occ_one) begin
                        r_buf0 <= w_cap_pkt;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= w_cap_pkt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Saturating stall and drop counters, frozen while in done mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_drop_cnt  <= '0;
        end else if (!is_done_mode) begin
            if (w_stall && (r_stall_cnt != c_cnt_max)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_drop && (r_drop_cnt != c_cnt_max)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_port_arbiter
// Brief    : Self-checking bench for output_port_arbiter. A queue-based model
//            of the arbiter, skid buffer and counters predicts every output
//            cycle by cycle under directed phases and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_port_arbiter;

    localparam int NP = 4;
    localparam int IB = 2;
    localparam int PB = 97;
    localparam int CB = 32;

    typedef logic [PB-1:0] pkt_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     port_empty;
    logic [NP-1:0]     port_credit;
    logic [NP*PB-1:0]  port_pkt;
    logic [NP-1:0]     rd_en_sel;
    logic [PB-1:0]     out_pkt;
    logic              out_valid;
    logic              out_ready;
    logic [IB-1:0]     grant_idx;
    logic              is_done_mode;
    logic [CB-1:0]     stall_cnt;
    logic [CB-1:0]     drop_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    pkt_t          q[$];
    pkt_t          m_last;
    int            m_infl;
    int            m_idx;
    int            m_rr;
    int            m_grant;
    logic [CB-1:0] m_stall;
    logic [CB-1:0] m_drop;

    output_port_arbiter #(
        .NUM_PORTS    (NP),
        .PORT_IDX_BITS(IB),
        .PACKET_BITS  (PB),
        .CNT_BITS     (CB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .port_empty  (port_empty),
        .port_credit (port_credit),
        .port_pkt    (port_pkt),
        .rd_en_sel   (rd_en_sel),
        .out_pkt     (out_pkt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .grant_idx   (grant_idx),
        .is_done_mode(is_done_mode),
        .stall_cnt   (stall_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_last  = '0;
        m_infl  = 0;
        m_idx   = 0;
        m_rr    = NP - 1;
        m_grant = 0;
        m_stall = '0;
        m_drop  = '0;
    endtask

    // One clock: drive inputs at negedge, compare outputs, advance the model.
    task automatic cycle(input logic [NP-1:0] empt, input logic [NP-1:0] cred,
                         input bit rdy, input bit done, input bit rst, input int drop_pct);
        logic [NP-1:0] elig;
        logic [NP-1:0] exp_sel;
        bit            exp_valid;
        pkt_t          exp_pkt;
        pkt_t          cap;
        bit            pop;
        bit            issue;
        int            g;
        int            j;
        bit            vb;

        @(negedge clk);
        port_empty   = empt;
        port_credit  = cred;
        out_ready    = rdy;
        is_done_mode = done;
        reset        = rst;
        for (int i = 0; i < NP; i++) begin
            vb = ($urandom_range(99) >= drop_pct);
            port_pkt[i*PB +: PB] = {vb, $urandom, $urandom, $urandom};
        end
        #1;

        elig      = ~empt & cred;
        exp_valid = (q.size() > 0);
        exp_pkt   = exp_valid ? q[0] : m_last;
        pop       = exp_valid && rdy;
        g = -1;
        for (int k = 1; k <= NP; k++) begin
            j = (m_rr + k) % NP;
            if (g < 0 && elig[j]) g = j;
        end
        issue   = !rst && (q.size() + m_infl - (pop ? 1 : 0) < 2) && (g >= 0);
        exp_sel = '0;
        if (issue) exp_sel[g] = 1'b1;

        check("rd_en_sel", rd_en_sel, exp_sel);
        check("out_valid", out_valid, exp_valid);
        check("out_pkt", out_pkt, exp_pkt);
        check("grant_idx", grant_idx, m_grant);
        check("stall_cnt", stall_cnt, m_stall);
        check("drop_cnt", drop_cnt, m_drop);
        check("occupancy", dut.r_occ, q.size());

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (pop) m_last = q.pop_front();
            if (m_infl != 0) begin
                cap = port_pkt[m_idx*PB +: PB];
                if (cap[PB-1]) q.push_back(cap);
                else if (!done && m_drop != '1) m_drop++;
            end
            if (exp_valid && !rdy && !done && m_stall != '1) m_stall++;
            if (issue) begin
                m_rr    = g;
                m_grant = g;
                m_idx   = g;
                m_infl  = 1;
            end else begin
                m_infl = 0;
            end
        end
        if (q.size() > 2) begin
            errors++;
            $display("FAIL model_overflow actual=%0d expected<=2", q.size());
        end
    endtask

    initial begin
        reset        = 1'b1;
        port_empty   = '1;
        port_credit  = '0;
        port_pkt     = '0;
        out_ready    = 1'b0;
        is_done_mode = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state
        repeat (2) cycle(4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 0);

        // Single port: only port 2 eligible
        repeat (15) cycle(4'b1011, 4'hF, 1'b1, 1'b0, 1'b0, 0);

        // Fairness: all ports eligible, sink always ready
        repeat (12) cycle(4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 0);

        // Backpressure then release
        repeat (5)  cycle(4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 0);
        repeat (10) cycle(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 0);
        repeat (10) cycle(4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 0);

        // Credit loss: some returned packets carry valid bit 0
        repeat (30) cycle(4'h0, 4'hF, 1'($urandom_range(1)), 1'b0, 1'b0, 30);

        // Done mode during stalls, then normal flow
        repeat (10) cycle(4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 0);
        repeat (10) cycle(4'h0, 4'hF, 1'b1, 1'b1, 1'b0, 0);
        repeat (3)  cycle(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 0);

        // Reset mid-stream with a full buffer
        repeat (4)  cycle(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 0);
        cycle(4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 0);
        repeat (8)  cycle(4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(4'($urandom), 4'($urandom | $urandom),
                  ($urandom_range(3) != 0),
                  ($urandom_range(15) == 0),
                  ($urandom_range(199) == 0),
                  10);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Shares one leaf-to-network packet lane among NUM_PORTS output-port queues.
- Each cycle it picks one eligible port round-robin and drives that port's one-hot rd_en_sel.
- The selected port returns its packet one cycle later. The arbiter captures it into a 2-entry skid buffer and presents it to the network with a valid/ready handshake.
- No packet is ever lost to network backpressure.

Parameters:
- NUM_PORTS, 4, number of output-port queues arbitrated.
- PORT_IDX_BITS, 2, width of a port index; must satisfy 2**PORT_IDX_BITS >= NUM_PORTS.
- PACKET_BITS, 97, packet width; bit PACKET_BITS-1 is the packet valid bit.
- CNT_BITS, 32, width of the performance counters.

Ports:
- clk  in  1  clock, shared by the ports and the network interface.
- reset  in  1  reset, synchronous, active-high.
- port_empty  in  NUM_PORTS  queue-empty flag from each output port.
- port_credit  in  NUM_PORTS  per-port flag, 1 when that port's FreeCnt > 0.
- port_pkt  in  NUM_PORTS*PACKET_BITS  registered packet from each port; slice i = port i.
- rd_en_sel  out  NUM_PORTS  one-hot (or zero) read select to the ports.
- out_pkt  out  PACKET_BITS  head packet toward the network.
- out_valid  out  1  out_pkt holds a packet.
- out_ready  in  1  network accepts out_pkt this cycle.
- grant_idx  out  PORT_IDX_BITS  index of the most recent grant.
- is_done_mode  in  1  freezes the counters when high.
- stall_cnt  out  CNT_BITS  cycles where out_valid && !out_ready.
- drop_cnt  out  CNT_BITS  issues whose returned packet had valid bit 0.

Behaviour:
- Reset values:
  - skid occupancy occ = 0; out_valid = 0; out_pkt = 0.
  - inflight = 0; rr_ptr = NUM_PORTS-1, so port 0 has first priority.
  - grant_idx = 0; stall_cnt = 0; drop_cnt = 0.
  - rd_en_sel = 0 while reset is high.
- Eligibility: eligible[i] = !port_empty[i] && port_credit[i].
- Pop: pop = out_valid && out_ready.
- Space check: issue is allowed only when occ + inflight - pop < 2, where inflight = 1 if an issue happened last cycle.
- Issue: when allowed and any port is eligible:
  - rd_en_sel = one-hot of the first eligible index searching rr_ptr+1, rr_ptr+2, … with wrap modulo NUM_PORTS.
  - rd_en_sel is combinational from registered state and current inputs.
  - On an issue: rr_ptr <= granted index; grant_idx <= granted index; inflight <= 1; issued_idx register <= granted index.
  - With no issue: rr_ptr and grant_idx hold; inflight <= 0.
- Capture (cycle after issue): pkt = port_pkt slice[issued_idx].
  - If pkt[PACKET_BITS-1] = 1: push pkt into the skid buffer.
  - Otherwise (the port declined because its credit dropped): no push, and drop_cnt increments.
- Skid buffer:
  - 2 entries, FIFO order; out_pkt = head; out_valid = (occ > 0).
  - Push and pop in the same cycle: occ unchanged, order preserved.
  - Pop with occ = 1 and no push: out_valid = 0 next cycle; out_pkt holds its last value.
  - occ must never exceed 2; the bench asserts this.
- Throughput: with out_ready held high and ports eligible, one packet per cycle.
  - First out_valid appears 2 cycles after the first issue.
- Backpressure: when out_ready = 0 and occ = 2, there is no issue, and in-flight packets always fit in the buffer.
- Counters:
  - stall_cnt and drop_cnt saturate at all-ones.
  - Both hold while is_done_mode = 1.
- Reset mid-operation: the skid buffer contents and in-flight packet are discarded. Port queues are not affected beyond reads already issued.

Test Plan:
- Single port: port 2 eligible, others empty, out_ready = 1 → rd_en_sel = 4'b0100 every cycle; out_valid rises 2 cycles after the first issue; packets arrive in order; grant_idx = 2.
- Fairness: all 4 ports eligible, out_ready = 1, 8 cycles → grant order 0,1,2,3,0,1,2,3; one packet per cycle on out_pkt.
- Backpressure: all ports eligible, out_ready = 0 from cycle 5 → at most 2 packets buffered; rd_en_sel = 0 while occ = 2; stall_cnt increments each stalled cycle; release out_ready → buffered packets emerge first, in order, with no loss or duplication.
- Credit loss: port 1 issued but its returned packet has valid bit 0 → no push; drop_cnt = 1; occ unchanged; next grant continues from rr_ptr = 1.
- Done mode: is_done_mode = 1 during 10 stalled cycles → stall_cnt unchanged; arbitration and data flow continue normally.
- Reset mid-stream: reset asserted with occ = 2 → next cycle out_valid = 0, rd_en_sel = 0, counters 0; after release, port 0 is granted first.
